// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the LSU data-RAM initiator: funct3 width codes,
// FSM states and the access-width helpers.
package lsu_mem_initiator_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Byte mask of an access before it is shifted to its lane offset.
  function automatic logic [3:0] width_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_load_align.sv
// Merges up to two RAM words into one load result: shift by the byte offset,
// then sign- or zero-extend the byte, half or word.
module lsu_load_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] low;

  assign low = 32'(rdata_i >> {offset_i, 3'b000});

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{low[7]}}, low[7:0]};
      F3_H:    data_o = {{16{low[15]}}, low[15:0]};
      F3_W:    data_o = low;
      F3_BU:   data_o = {24'b0, low[7:0]};
      F3_HU:   data_o = {16'b0, low[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// CPU-side load/store initiator for the word-organised data RAM; splits
// word-crossing accesses into two beats and aligns/extends load data.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [AW-1:0] word_q;
  logic [31:0]   wdata_q, rdata0_q, rdata1_q;

  logic          accept, req_legal, split, err;
  logic [7:0]    m8;
  logic [63:0]   s64;
  logic [31:0]   load_data;
  logic          addr_unused;

  assign addr_unused = ^req_addr[31:AW+2];

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign req_legal = f3_legal(req_we, req_funct3);

  assign err   = !f3_legal(we_q, f3_q);
  assign m8    = {4'b0000, width_mask(f3_q)} << off_q;
  assign split = |m8[7:4];
  assign s64   = {32'b0, wdata_q} << {off_q, 3'b000};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_legal ? BEAT0 : WAIT;
      BEAT0:   state_d = split ? BEAT1 : WAIT;
      BEAT1:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = accept ? (req_legal ? BEAT0 : WAIT) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      off_q   <= req_addr[1:0];
      word_q  <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
    end
  end

  // RAM data lags mem_req by one cycle: beat0 data arrives during BEAT1
  // (split) or WAIT (unsplit); beat1 data always arrives during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == BEAT1) begin
      rdata0_q <= mem_rdata;
    end else if (state_q == WAIT) begin
      if (split) begin
        rdata1_q <= mem_rdata;
      end else begin
        rdata0_q <= mem_rdata;
        rdata1_q <= '0;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_q;
        mem_be    = we_q ? m8[3:0] : 4'b1111;
        mem_wdata = we_q ? s64[31:0] : 32'b0;
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_q + AW'(1);
        mem_be    = we_q ? m8[7:4] : 4'b1111;
        mem_wdata = we_q ? s64[63:32] : 32'b0;
      end
      default: ;
    endcase
  end

  lsu_load_align u_align (
    .rdata_i  ({rdata1_q, rdata0_q}),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (resp_valid && !we_q && !err) ? load_data : 32'b0;

endmodule
